ours_axi4_ar_arb_r_route: RTL and testbench

- N-to-1 AXI4 read-channel scheduler. Arbitrates read-address (AR) requests from N_INPUT requesters onto one master AR port, round-robin.
- Tags each issued AR with the source index and tracks outstanding bursts per requester. Uses the returned tag to route the R channel back to the owning requester.
- Sits between requester-side buffers and the shared downstream read port, pairing with the R-channel buffering/arbitration logic.

---
 rtl/ours_axi4_ar_arb_r_route.sv | 181 ++++++++++++++++++
 tb/tb_ours_axi4_ar_arb_r_route.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ours_axi4_ar_arb_r_route.sv
// N-to-1 AXI4 read scheduler: round-robin AR arbitration with source tagging and tag-based R routing.
// Optional build macro OURS_AXI4_AR_ARB_STALL_CNT_EN adds the 32-bit ar_stall_cnt output.
module ours_axi4_ar_arb_r_route #(
    parameter int N_INPUT        = 2,
    parameter int AR_WIDTH       = 48,
    parameter int R_WIDTH        = 40,
    parameter int RLAST_POSITION = 0,
    parameter int MAX_OUTST      = 4,
    parameter int IDX_W          = (N_INPUT > 1) ? $clog2(N_INPUT) : 1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [N_INPUT-1:0]                  slave_arvld,
    input  logic [N_INPUT-1:0][AR_WIDTH-1:0]    slave_ar,
    output logic [N_INPUT-1:0]                  slave_arrdy,
    output logic                                master_arvld,
    output logic [IDX_W+AR_WIDTH-1:0]           master_ar,
    input  logic                                master_arrdy,
    input  logic                                master_rvld,
    input  logic [IDX_W+R_WIDTH-1:0]            master_r,
    output logic                                master_rrdy,
    output logic [N_INPUT-1:0]                  slave_rvld,
    output logic [N_INPUT-1:0][R_WIDTH-1:0]     slave_r,
    input  logic [N_INPUT-1:0]                  slave_rrdy,
    output logic                                outst_busy,
    output logic                                route_err
`ifdef OURS_AXI4_AR_ARB_STALL_CNT_EN
    ,
    output logic [31:0]                         ar_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [IDX_W:0]   N_LIM   = (IDX_W + 1)'(N_INPUT);

    logic [0:0]                      r_state;
    logic [IDX_W-1:0]                r_ptr;
    logic [N_INPUT-1:0][CNT_W-1:0]   r_cnt;
    logic [IDX_W+AR_WIDTH-1:0]       r_ar;
    logic                            r_busy;
    logic                            r_err;

    logic [N_INPUT-1:0]              w_elig;
    logic                            w_gnt_vld;
    logic [IDX_W-1:0]                w_gnt_idx;
    logic [IDX_W-1:0]                w_ptr_nxt;
    logic [IDX_W-1:0]                w_tag;
    logic                            w_tag_ok;
    logic                            w_r_done;
    logic                            w_bad_tag;
    logic                            w_dec_err;
    logic                            w_busy_nxt;
    logic [N_INPUT-1:0][CNT_W-1:0]   w_cnt_nxt;

    assign master_arvld = (r_state == ST_HOLD);
    assign master_ar    = r_ar;
    assign outst_busy   = r_busy;
    assign route_err    = r_err;

    // Round-robin pick: scan offsets high to low so the lowest eligible offset from the pointer wins.
    always_comb begin
        w_elig    = '0;
        w_gnt_idx = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            w_elig[i] = slave_arvld[i] & (r_cnt[i] < CNT_MAX);
        end
        for (int k = N_INPUT - 1; k >= 0; k--) begin
            w_gnt_idx = w_elig[(int'(r_ptr) + k) % N_INPUT] ?
                        IDX_W'((int'(r_ptr) + k) % N_INPUT) : w_gnt_idx;
        end
        w_gnt_vld = (r_state == ST_IDLE) & rstn & (|w_elig);
        if (w_gnt_idx == IDX_W'(N_INPUT - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gnt_idx + IDX_W'(1);
        end
        for (int i = 0; i < N_INPUT; i++) begin
            slave_arrdy[i] = w_gnt_vld & (w_gnt_idx == IDX_W'(i));
        end
    end

    // R routing by tag; an unmatched (invalid) tag leaves master_rrdy high so the beat is sunk.
    always_comb begin
        w_tag       = master_r[IDX_W+R_WIDTH-1 -: IDX_W];
        w_tag_ok    = ({1'b0, w_tag} < N_LIM);
        master_rrdy = 1'b1;
        slave_rvld  = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            slave_r[i] = master_r[R_WIDTH-1:0];
            if (w_tag == IDX_W'(i)) begin
                slave_rvld[i] = master_rvld;
                master_rrdy   = slave_rrdy[i];
            end else begin
                slave_rvld[i] = 1'b0;
            end
        end
        w_r_done  = master_rvld & master_rrdy & master_r[RLAST_POSITION] & w_tag_ok;
        w_bad_tag = master_rvld & ~w_tag_ok;
    end

    // Outstanding counters: grant increments, completed burst decrements, both together cancel.
    always_comb begin
        w_dec_err  = 1'b0;
        w_busy_nxt = 1'b0;
        for (int i = 0; i < N_INPUT; i++) begin
            case ({w_gnt_vld & (w_gnt_idx == IDX_W'(i)), w_r_done & (w_tag == IDX_W'(i))})
                2'b10: w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                2'b01: begin
                    if (r_cnt[i] == '0) begin
                        w_cnt_nxt[i] = r_cnt[i];
                        w_dec_err    = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                    end
                end
                default: w_cnt_nxt[i] = r_cnt[i];
            endcase
            w_busy_nxt = w_busy_nxt | (w_cnt_nxt[i] != '0);
        end
    end

    // AR FSM, pointer, counters and sticky error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_ar    <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_state <= ST_HOLD;
                        r_ar    <= {w_gnt_idx, slave_ar[w_gnt_idx]};
                        r_ptr   <= w_ptr_nxt;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (master_arrdy) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            r_cnt  <= w_cnt_nxt;
            r_busy <= w_busy_nxt;
            if (w_bad_tag | w_dec_err) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

`ifdef OURS_AXI4_AR_ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    assign ar_stall_cnt = r_stall_cnt;

    // Saturating count of cycles the downstream port back-pressures a valid AR.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == ST_HOLD) && !master_arrdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_ours_axi4_ar_arb_r_route.sv
// Directed bench for ours_axi4_ar_arb_r_route: a 2-requester instance plus a 3-requester instance for invalid tags.
module tb_ours_axi4_ar_arb_r_route;

    logic                  clk;
    logic                  rstn;
    logic [1:0]            arvld;
    logic [1:0][47:0]      ar;
    logic [1:0]            arrdy;
    logic                  m_arvld;
    logic [48:0]           m_ar;
    logic                  m_arrdy;
    logic                  m_rvld;
    logic [40:0]           m_r;
    logic                  m_rrdy;
    logic [1:0]            s_rvld;
    logic [1:0][39:0]      s_r;
    logic [1:0]            s_rrdy;
    logic                  busy;
    logic                  err;

    logic [2:0]            d3_arvld;
    logic [2:0][47:0]      d3_ar;
    logic [2:0]            d3_arrdy;
    logic                  d3_m_arvld;
    logic [49:0]           d3_m_ar;
    logic                  d3_m_rvld;
    logic [41:0]           d3_m_r;
    logic                  d3_m_rrdy;
    logic [2:0]            d3_s_rvld;
    logic [2:0][39:0]      d3_s_r;
    logic [2:0]            d3_s_rrdy;
    logic                  d3_busy;
    logic                  d3_err;
`ifdef OURS_AXI4_AR_ARB_STALL_CNT_EN
    logic [31:0]           stall;
    logic [31:0]           d3_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ours_axi4_ar_arb_r_route u_dut (
        .clk(clk), .rstn(rstn),
        .slave_arvld(arvld), .slave_ar(ar), .slave_arrdy(arrdy),
        .master_arvld(m_arvld), .master_ar(m_ar), .master_arrdy(m_arrdy),
        .master_rvld(m_rvld), .master_r(m_r), .master_rrdy(m_rrdy),
        .slave_rvld(s_rvld), .slave_r(s_r), .slave_rrdy(s_rrdy),
        .outst_busy(busy), .route_err(err)
`ifdef OURS_AXI4_AR_ARB_STALL_CNT_EN
        , .ar_stall_cnt(stall)
`endif
    );

    ours_axi4_ar_arb_r_route #(.N_INPUT(3)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .slave_arvld(d3_arvld), .slave_ar(d3_ar), .slave_arrdy(d3_arrdy),
        .master_arvld(d3_m_arvld), .master_ar(d3_m_ar), .master_arrdy(1'b1),
        .master_rvld(d3_m_rvld), .master_r(d3_m_r), .master_rrdy(d3_m_rrdy),
        .slave_rvld(d3_s_rvld), .slave_r(d3_s_r), .slave_rrdy(d3_s_rrdy),
        .outst_busy(d3_busy), .route_err(d3_err)
`ifdef OURS_AXI4_AR_ARB_STALL_CNT_EN
        , .ar_stall_cnt(d3_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:0] g;
        logic [5:0] rr_pat;
        logic [5:0] last_pat;
        logic [39:0] pl;

        rstn = 1'b0; arvld = '0; ar = '0; m_arrdy = 1'b1; m_rvld = 1'b0; m_r = '0; s_rrdy = '0;
        d3_arvld = '0; d3_ar = '0; d3_m_rvld = 1'b0; d3_m_r = '0; d3_s_rrdy = '0;
        tick(); tick();
        rstn = 1'b1;
        check("rst_arvld", m_arvld, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_arrdy", arrdy, 0);

        // Fairness: both requesting, grants alternate 0,1,0,1, one AR per two cycles.
        arvld = 2'b11; ar[0] = 48'h0000_AAAA_0000; ar[1] = 48'h0000_BBBB_0001; m_arrdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            #1;
            check("fair_rdy", arrdy, (g == 1'b1) ? 2'b10 : 2'b01);
            check("fair_idle_vld", m_arvld, 0);
            tick();
            check("fair_vld", m_arvld, 1);
            check("fair_ar", m_ar, {g, ar[g]});
            check("fair_hold_rdy", arrdy, 0);
            tick();
        end
        arvld = 2'b00;
        check("fair_busy", busy, 1);
        check("fair_cnt0", u_dut.r_cnt[0], 2);
        check("fair_cnt1", u_dut.r_cnt[1], 2);
`ifdef OURS_AXI4_AR_ARB_STALL_CNT_EN
        check("fair_stall", stall, 0);
`endif

        // Routing: burst on tag 1, slave_rrdy[1] drives master_rrdy, decrement only on rlast handshake.
        rr_pat = 6'b101101; last_pat = 6'b110000; s_rrdy[0] = 1'b1; m_rvld = 1'b1;
        for (int c = 0; c < 6; c++) begin
            pl = {32'hCAFE_0000 + 32'(c), 7'd0, last_pat[c]};
            m_r = {1'b1, pl};
            s_rrdy[1] = rr_pat[c];
            #1;
            check("route_rrdy", m_rrdy, rr_pat[c]);
            check("route_rvld", s_rvld, 2'b10);
            check("route_r0", s_r[0], pl);
            check("route_r1", s_r[1], pl);
            tick();
            if (c == 4) check("route_cnt1_hold", u_dut.r_cnt[1], 2);
        end
        check("route_cnt1_dec", u_dut.r_cnt[1], 1);
        check("route_cnt0", u_dut.r_cnt[0], 2);
        m_rvld = 1'b0; s_rrdy = '0;

        // Reset in HOLD with downstream stalled.
        arvld = 2'b01; m_arrdy = 1'b0;
        #1 check("mid_rdy", arrdy, 2'b01);
        tick(); tick(); tick();
        check("mid_hold", m_arvld, 1);
`ifdef OURS_AXI4_AR_ARB_STALL_CNT_EN
        check("mid_stall", stall, 2);
`endif
        rstn = 1'b0;
        #1 check("rst_gate_rdy", arrdy, 0);
        tick();
        check("mid_arvld", m_arvld, 0);
        check("mid_busy", busy, 0);
        check("mid_cnt0", u_dut.r_cnt[0], 0);
        check("mid_cnt1", u_dut.r_cnt[1], 0);
        check("mid_ptr", u_dut.r_ptr, 0);
`ifdef OURS_AXI4_AR_ARB_STALL_CNT_EN
        check("mid_stall_clr", stall, 0);
`endif
        rstn = 1'b1; m_arrdy = 1'b1;

        // Limit: four ARs issue, the fifth waits for an rlast on tag 0.
        for (int k = 0; k < 4; k++) begin
            #1 check("lim_rdy", arrdy, 2'b01);
            tick();
            check("lim_ar", m_ar, {1'b0, ar[0]});
            tick();
        end
        #1;
        check("lim_cnt4", u_dut.r_cnt[0], 4);
        check("lim_block", arrdy, 0);
        tick();
        check("lim_noar", m_arvld, 0);
        check("lim_block2", arrdy, 0);
        m_rvld = 1'b1; m_r = {1'b0, 40'h1}; s_rrdy = 2'b01;
        #1 check("lim_sink_rrdy", m_rrdy, 1);
        tick();
        m_rvld = 1'b0;
        #1;
        check("lim_cnt3", u_dut.r_cnt[0], 3);
        check("lim_5th_rdy", arrdy, 2'b01);
        tick();
        check("lim_5th_vld", m_arvld, 1);
        arvld = 2'b00;
        tick();

        // Same-cycle accept and rlast on requester 0 with cnt 2.
        m_rvld = 1'b1;
        tick(); tick();
        m_rvld = 1'b0;
        #1 check("same_pre", u_dut.r_cnt[0], 2);
        arvld = 2'b01; m_rvld = 1'b1;
        #1;
        check("same_rdy", arrdy, 2'b01);
        check("same_rrdy", m_rrdy, 1);
        tick();
        check("same_cnt", u_dut.r_cnt[0], 2);
        check("same_vld", m_arvld, 1);
        arvld = 2'b00; m_rvld = 1'b0;
        tick();

        // Completion on a requester with nothing outstanding.
        check("zero_pre_err", err, 0);
        m_rvld = 1'b1; m_r = {1'b1, 40'h1}; s_rrdy = 2'b10;
        tick();
        m_rvld = 1'b0;
        #1;
        check("zero_err", err, 1);
        check("zero_cnt1", u_dut.r_cnt[1], 0);

        // Three requesters: valid tag 2 routes, tag 3 is sunk and flags an error.
        d3_m_rvld = 1'b1; d3_m_r = {2'd2, 40'h5}; d3_s_rrdy = 3'b100;
        #1;
        check("d3_rvld2", d3_s_rvld, 3'b100);
        check("d3_rrdy2", d3_m_rrdy, 1);
        d3_s_rrdy = 3'b000;
        #1 check("d3_rrdy2_lo", d3_m_rrdy, 0);
        d3_m_r = {2'd3, 40'h1};
        #1;
        check("bad_rrdy", d3_m_rrdy, 1);
        check("bad_rvld", d3_s_rvld, 0);
        check("bad_pre_err", d3_err, 0);
        tick();
        d3_m_rvld = 1'b0;
        #1 check("bad_err", d3_err, 1);
        tick(); tick();
        check("bad_sticky", d3_err, 1);
        check("bad_cnt", d3_busy, 0);
        rstn = 1'b0;
        tick();
        check("bad_err_clr", d3_err, 0);
        check("zero_err_clr", err, 0);
        rstn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
